// File: rtl/sid_write_sched.sv
// SID register-write scheduler: queued timed writes plus direct writes,
// merged onto one WR/ADDR/DATA port, with the 1 MHz CLKen strobe.
module sid_write_sched #(
  parameter int CLK_DIV = 12,
  parameter int FIFO_AW = 4
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               H_VALID,
  output logic               H_READY,
  input  logic [15:0]        H_DELAY,
  input  logic [4:0]         H_ADDR,
  input  logic [7:0]         H_DATA,
  input  logic               D_WR,
  input  logic [4:0]         D_ADDR,
  input  logic [7:0]         D_DATA,
  input  logic               FLUSH,
  output logic               CLKen,
  output logic               WR,
  output logic [4:0]         ADDR,
  output logic [7:0]         DATA,
  output logic [FIFO_AW:0]   LEVEL,
  output logic               BUSY
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    ISSUE
  } state_t;

  state_t            state;
  logic [DW-1:0]     div;
  logic [FIFO_AW:0]  count;
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [28:0]       mem [DEPTH];
  logic [28:0]       head;
  logic [15:0]       cur_delay;
  logic [4:0]        cur_addr;
  logic [7:0]        cur_data;
  logic              push;
  logic              pop;
  logic              issue_go;

  assign H_READY  = (count != (FIFO_AW+1)'(DEPTH));
  assign LEVEL    = count;
  assign BUSY     = (state != IDLE) || (count != '0);
  assign head     = mem[rptr];
  assign push     = H_VALID && H_READY && !FLUSH;
  assign pop      = (state == LOAD) && !FLUSH;
  assign issue_go = (state == ISSUE) && !D_WR && !FLUSH;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      div   <= '0;
      CLKen <= 1'b0;
    end else begin
      CLKen <= (div == DW'(CLK_DIV - 1));
      if (div == DW'(CLK_DIV - 1)) div <= '0;
      else                         div <= div + DW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {H_DELAY, H_ADDR, H_DATA};
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (FLUSH) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      cur_delay <= '0;
      cur_addr  <= '0;
      cur_data  <= '0;
      WR        <= 1'b0;
      ADDR      <= '0;
      DATA      <= '0;
    end else begin
      // Direct writes always win the port; a blocked ISSUE simply retries.
      if (D_WR) begin
        WR   <= 1'b1;
        ADDR <= D_ADDR;
        DATA <= D_DATA;
      end else if (issue_go) begin
        WR   <= 1'b1;
        ADDR <= cur_addr;
        DATA <= cur_data;
      end else begin
        WR <= 1'b0;
      end

      if (FLUSH) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (count != '0) state <= LOAD;
          end
          LOAD: begin
            cur_delay <= head[28:13];
            cur_addr  <= head[12:8];
            cur_data  <= head[7:0];
            state     <= (head[28:13] == 16'd0) ? ISSUE : WAIT;
          end
          WAIT: begin
            if (CLKen) begin
              cur_delay <= cur_delay - 16'd1;
              if (cur_delay == 16'd1) state <= ISSUE;
            end
          end
          ISSUE: begin
            if (!D_WR) state <= (count != '0) ? LOAD : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sid_write_sched.sv
// Scoreboard bench for sid_write_sched: stimulus queues expected writes,
// a negedge monitor matches every WR pulse and checks the CLKen phase.
module tb_sid_write_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_valid = 1'b0;
  logic        h_ready;
  logic [15:0] h_delay = '0;
  logic [4:0]  h_addr = '0;
  logic [7:0]  h_data = '0;
  logic        d_wr = 1'b0;
  logic [4:0]  d_addr = '0;
  logic [7:0]  d_data = '0;
  logic        flush = 1'b0;
  logic        clken;
  logic        wr;
  logic [4:0]  addr;
  logic [7:0]  data;
  logic [4:0]  level;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t sb[$];

  sid_write_sched #(.CLK_DIV(12), .FIFO_AW(4)) dut (
    .CLK(clk), .RESETn(rst_n),
    .H_VALID(h_valid), .H_READY(h_ready),
    .H_DELAY(h_delay), .H_ADDR(h_addr), .H_DATA(h_data),
    .D_WR(d_wr), .D_ADDR(d_addr), .D_DATA(d_data),
    .FLUSH(flush), .CLKen(clken),
    .WR(wr), .ADDR(addr), .DATA(data),
    .LEVEL(level), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; CLKen is due after every 12th.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("clken_phase", 32'(clken), 32'(cyc != 0 && cyc % 12 == 0));
    if (wr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h at %0d expected none",
                 addr, data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_data", 32'(data), 32'(e.d));
        if (e.at >= 0) chk("wr_time", cyc, e.at);
      end
    end
  end

  // Edge at which WR is visible for an entry pushed at edge p from IDLE.
  function automatic int exp_edge(input int p, input int dly);
    int e;
    if (dly == 0) return p + 3;
    e = p + 3;
    while ((e - 1) % 12 != 0) e++;
    e += 12 * (dly - 1);
    return e + 1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int n;
    int p;

    // Reset values and free-running CLKen
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clken", 32'(clken), 0);
    chk("rst_ready", 32'(h_ready), 1);
    rst_n = 1'b1;
    n = 0;
    repeat (48) begin
      @(negedge clk);
      if (clken) n++;
    end
    chk("clken_count", n, 4);

    // Single entry, delay 3
    @(negedge clk);
    h_valid = 1'b1;
    h_delay = 16'd3;
    h_addr = 5'h04;
    h_data = 8'h41;
    p = cyc + 1;
    sb.push_back('{5'h04, 8'h41, exp_edge(p, 3)});
    @(negedge clk);
    h_valid = 1'b0;
    drain(200);
    repeat (2) @(negedge clk);
    chk("t2_level", 32'(level), 0);
    chk("t2_busy", 32'(busy), 0);

    // Blocker in WAIT, then 16 zero-delay entries fill the FIFO
    @(negedge clk);
    h_valid = 1'b1;
    h_delay = 16'd3;
    h_addr = 5'h1E;
    h_data = 8'hEE;
    sb.push_back('{5'h1E, 8'hEE, -1});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      h_delay = 16'd0;
      h_addr = 5'(i);
      h_data = 8'(i);
      sb.push_back('{5'(i), 8'(i), -1});
    end
    @(negedge clk);
    h_valid = 1'b0;
    chk("full_level", 32'(level), 16);
    chk("full_ready", 32'(h_ready), 0);
    h_valid = 1'b1;
    h_addr = 5'h1F;
    h_data = 8'hFF;
    @(negedge clk);
    h_valid = 1'b0;
    chk("full_ignored", 32'(level), 16);
    drain(1000);
    repeat (4) @(negedge clk);
    chk("t3_level", 32'(level), 0);

    // Direct writes starve ISSUE for three cycles
    @(negedge clk);
    h_valid = 1'b1;
    h_delay = 16'd0;
    h_addr = 5'h07;
    h_data = 8'h5C;
    p = cyc + 1;
    @(negedge clk);
    h_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d_wr = 1'b1;
    d_addr = 5'h01;
    d_data = 8'hAA;
    sb.push_back('{5'h01, 8'hAA, p + 3});
    sb.push_back('{5'h01, 8'hAA, p + 4});
    sb.push_back('{5'h01, 8'hAA, p + 5});
    sb.push_back('{5'h07, 8'h5C, p + 6});
    repeat (3) @(negedge clk);
    d_wr = 1'b0;
    drain(50);
    repeat (4) @(negedge clk);

    // Flush during WAIT, with a coincident direct write and push
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      h_valid = 1'b1;
      h_delay = 16'd100;
      h_addr = 5'(16 + i);
      h_data = 8'(i);
    end
    @(negedge clk);
    h_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1;
    d_wr = 1'b1;
    d_addr = 5'h12;
    d_data = 8'h34;
    h_valid = 1'b1;
    h_delay = 16'd0;
    h_addr = 5'h1D;
    h_data = 8'h99;
    sb.push_back('{5'h12, 8'h34, cyc + 1});
    @(negedge clk);
    flush = 1'b0;
    d_wr = 1'b0;
    h_valid = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_busy", 32'(busy), 0);
    repeat (3600) @(negedge clk);
    chk("flush_quiet", sb.size(), 0);

    // Async reset mid-WAIT with three entries queued
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      h_valid = 1'b1;
      h_delay = 16'd50;
      h_addr = 5'(8 + i);
      h_data = 8'(8'h80 + i);
    end
    @(negedge clk);
    h_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_level", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr", 32'(wr), 0);
    chk("arst_addr", 32'(addr), 0);
    chk("arst_data", 32'(data), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_clken", 32'(clken), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (clken) n++;
    end
    chk("rerst_clken_count", n, 2);
    repeat (700) @(negedge clk);
    chk("end_level", 32'(level), 0);
    chk("end_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
